execute_stage: RTL and testbench

- Y86-64 pipeline execute stage that sits around the 64-bit ALU.
- Drives the ALU select and operand lines from the decode-stage bundle, then consumes the ALU result and overflow flag.
- Owns the condition-code register and evaluates jXX/cmovXX conditions.
- Registers the execute-to-memory (E/M) pipeline bundle behind a valid/ready handshake.

---
 rtl/y86_pkg.sv | 56 +++++
 rtl/cond_eval.sv | 32 +++
 rtl/execute_stage.sv | 193 +++++++++++++++++++
 tb/tb_execute_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the Y86-64 pipeline.
//   - instruction codes (I_HALT..I_POPQ)
//   - ALU select encodings
//   - status codes
//   - the "no register" id
//   - condition-code function codes for jXX/cmovXX
package y86_pkg;

  localparam int unsigned W_DEF          = 64;
  localparam int unsigned STACK_STEP_DEF = 8;
  localparam logic [3:0]  RNONE_DEF      = 4'hF;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // OPq function codes
  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  // ALU select as seen on the alu_sel port
  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_XOR = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11   // p - q
  } alu_sel_e;

  // Status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Condition function codes (shared by jXX and cmovXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition evaluator.
// Ports:
//   cc   in  3  condition codes {ZF,SF,OF}
//   ifun in  4  condition function code
//   cnd  out 1  condition holds
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf, sf, of;
  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage wrapped around an external 64-bit ALU.
// Drives the ALU from the decode bundle, owns the condition-code register,
// evaluates jXX/cmovXX conditions and registers the E/M bundle behind a
// valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          decode-side handshake
//   in_stat..in_dstM           decode bundle
//   flush                      squash registered bundle, accept nothing
//   cc_inhibit                 block CC writes (downstream exception)
//   alu_sel/alu_p/alu_q        ALU drive
//   alu_r/alu_ofw              ALU result and signed overflow
//   out_valid/out_ready        memory-side handshake
//   e_stat..e_dstM             registered E/M bundle
//   cc                         condition codes {ZF,SF,OF}
module execute_stage
  import y86_pkg::*;
#(
  parameter int unsigned W          = W_DEF,
  parameter int unsigned STACK_STEP = STACK_STEP_DEF,
  parameter logic [3:0]  RNONE      = RNONE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_stat,
  input  logic [3:0]   in_icode,
  input  logic [3:0]   in_ifun,
  input  logic [W-1:0] in_valA,
  input  logic [W-1:0] in_valB,
  input  logic [W-1:0] in_valC,
  input  logic [3:0]   in_dstE,
  input  logic [3:0]   in_dstM,
  input  logic         flush,
  input  logic         cc_inhibit,
  output logic [1:0]   alu_sel,
  output logic [W-1:0] alu_p,
  output logic [W-1:0] alu_q,
  input  logic [W-1:0] alu_r,
  input  logic         alu_ofw,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   e_stat,
  output logic [3:0]   e_icode,
  output logic         e_cnd,
  output logic [W-1:0] e_valE,
  output logic [W-1:0] e_valA,
  output logic [3:0]   e_dstE,
  output logic [3:0]   e_dstM,
  output logic [2:0]   cc
);

  localparam logic [W-1:0] STEP = W'(STACK_STEP);

  // Registered state
  logic         out_valid_q, out_valid_d;
  logic [2:0]   e_stat_q,    e_stat_d;
  logic [3:0]   e_icode_q,   e_icode_d;
  logic         e_cnd_q,     e_cnd_d;
  logic [W-1:0] e_valE_q,    e_valE_d;
  logic [W-1:0] e_valA_q,    e_valA_d;
  logic [3:0]   e_dstE_q,    e_dstE_d;
  logic [3:0]   e_dstM_q,    e_dstM_d;
  logic [2:0]   cc_q,        cc_d;

  logic         accept;
  logic         cnd;
  logic [W-1:0] alu_a, alu_b;
  alu_sel_e     sel;

  // ---------------- ALU drive ----------------
  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (in_icode)
      I_RRMOVQ, I_OPQ:             alu_a = in_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = in_valC;
      I_CALL, I_PUSHQ:             alu_a = '0 - STEP;
      I_RET, I_POPQ:               alu_a = STEP;
      default:                     alu_a = '0;
    endcase
    case (in_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = in_valB;
      default:                                                   alu_b = '0;
    endcase
  end

  always_comb begin
    sel = ALU_ADD;
    if (in_icode == I_OPQ) begin
      case (in_ifun)
        F_SUB:   sel = ALU_SUB;
        F_AND:   sel = ALU_AND;
        F_XOR:   sel = ALU_XOR;
        default: sel = ALU_ADD;
      endcase
    end
  end

  assign alu_sel = sel;
  assign alu_p   = alu_b;
  assign alu_q   = alu_a;

  // Condition uses the registered cc, i.e. before this instruction's own update.
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (in_ifun),
    .cnd  (cnd)
  );

  // ---------------- Handshake ----------------
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------- Next state ----------------
  always_comb begin
    out_valid_d = out_valid_q;
    e_stat_d    = e_stat_q;
    e_icode_d   = e_icode_q;
    e_cnd_d     = e_cnd_q;
    e_valE_d    = e_valE_q;
    e_valA_d    = e_valA_q;
    e_dstE_d    = e_dstE_q;
    e_dstM_d    = e_dstM_q;
    cc_d        = cc_q;

    if (flush) begin
      // Squash to a bubble; flush wins over any incoming bundle.
      out_valid_d = 1'b0;
      e_stat_d    = STAT_AOK;
      e_icode_d   = I_NOP;
      e_cnd_d     = 1'b0;
      e_dstE_d    = RNONE;
      e_dstM_d    = RNONE;
    end else if (accept) begin
      out_valid_d = 1'b1;
      e_stat_d    = in_stat;
      e_icode_d   = in_icode;
      e_cnd_d     = ((in_icode == I_RRMOVQ) || (in_icode == I_JXX)) ? cnd : 1'b0;
      e_valE_d    = alu_r;
      e_valA_d    = in_valA;
      // A not-taken cmov must not write its destination.
      e_dstE_d    = ((in_icode == I_RRMOVQ) && !cnd) ? RNONE : in_dstE;
      e_dstM_d    = in_dstM;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Only architecturally committed OPq instructions update the flags.
    if (accept && (in_icode == I_OPQ) && (in_stat == STAT_AOK) && !cc_inhibit) begin
      cc_d = {(alu_r == '0), alu_r[W-1], alu_ofw};
    end
  end

  // ---------------- State registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      e_stat_q    <= '0;
      e_icode_q   <= '0;
      e_cnd_q     <= 1'b0;
      e_valE_q    <= '0;
      e_valA_q    <= '0;
      e_dstE_q    <= RNONE;
      e_dstM_q    <= RNONE;
      cc_q        <= 3'b100;
    end else begin
      out_valid_q <= out_valid_d;
      e_stat_q    <= e_stat_d;
      e_icode_q   <= e_icode_d;
      e_cnd_q     <= e_cnd_d;
      e_valE_q    <= e_valE_d;
      e_valA_q    <= e_valA_d;
      e_dstE_q    <= e_dstE_d;
      e_dstM_q    <= e_dstM_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign e_stat    = e_stat_q;
  assign e_icode   = e_icode_q;
  assign e_cnd     = e_cnd_q;
  assign e_valE    = e_valE_q;
  assign e_valA    = e_valA_q;
  assign e_dstE    = e_dstE_q;
  assign e_dstM    = e_dstM_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed-vector bench for execute_stage with a behavioural
// reference model of the instruction semantics and a per-cycle compare process.
// A small behavioural ALU stands in for the external ALU.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_stat;
  logic [3:0]  in_icode, in_ifun;
  logic [63:0] in_valA, in_valB, in_valC;
  logic [3:0]  in_dstE, in_dstM;
  logic        flush, cc_inhibit;
  logic [1:0]  alu_sel;
  logic [63:0] alu_p, alu_q, alu_r;
  logic        alu_ofw;
  logic        out_valid, out_ready;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  e_dstE, e_dstM;
  logic [2:0]  cc;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_valA(in_valA), .in_valB(in_valB), .in_valC(in_valC),
    .in_dstE(in_dstE), .in_dstM(in_dstM),
    .flush(flush), .cc_inhibit(cc_inhibit),
    .alu_sel(alu_sel), .alu_p(alu_p), .alu_q(alu_q),
    .alu_r(alu_r), .alu_ofw(alu_ofw),
    .out_valid(out_valid), .out_ready(out_ready),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .cc(cc)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU.
  always_comb begin
    alu_r   = '0;
    alu_ofw = 1'b0;
    case (alu_sel)
      2'b00: alu_r = alu_p & alu_q;
      2'b01: alu_r = alu_p ^ alu_q;
      2'b10: begin
        alu_r   = alu_p + alu_q;
        alu_ofw = (alu_p[63] == alu_q[63]) && (alu_r[63] != alu_p[63]);
      end
      default: begin
        alu_r   = alu_p - alu_q;
        alu_ofw = (alu_p[63] != alu_q[63]) && (alu_r[63] != alu_p[63]);
      end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  function automatic logic cond_of(input logic [3:0] f, input logic [2:0] c);
    logic zf, sf, of;
    zf = c[2]; sf = c[1]; of = c[0];
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {signed overflow, valE} as the instruction semantics define them.
  function automatic logic [64:0] exec_of(input logic [3:0] ic, input logic [3:0] f,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    logic [63:0] r;
    logic ov;
    r = '0; ov = 1'b0;
    case (ic)
      4'h2:       r = a;
      4'h3:       r = c;
      4'h4, 4'h5: r = b + c;
      4'h6: case (f)
        4'd1: begin r = b - a; ov = (b[63] != a[63]) && (r[63] != b[63]); end
        4'd2: r = b & a;
        4'd3: r = b ^ a;
        default: begin r = b + a; ov = (b[63] == a[63]) && (r[63] != b[63]); end
      endcase
      4'h8, 4'hA: r = b - 64'd8;
      4'h9, 4'hB: r = b + 64'd8;
      default:    r = '0;
    endcase
    return {ov, r};
  endfunction

  logic        m_valid;
  logic [2:0]  m_stat, m_cc;
  logic [3:0]  m_icode, m_dstE, m_dstM;
  logic        m_cnd;
  logic [63:0] m_valE, m_valA;

  always @(posedge clk or negedge rst_n) begin
    logic acc, c;
    logic [64:0] ex;
    if (!rst_n) begin
      m_valid = 1'b0; m_cc = 3'b100;
      m_stat = '0; m_icode = '0; m_cnd = 1'b0; m_valE = '0; m_valA = '0;
      m_dstE = 4'hF; m_dstM = 4'hF;
    end else begin
      acc = in_valid && !flush && (!m_valid || out_ready);
      if (flush) begin
        m_valid = 1'b0; m_icode = 4'h1; m_dstE = 4'hF; m_dstM = 4'hF;
      end else if (acc) begin
        c  = cond_of(in_ifun, m_cc);
        ex = exec_of(in_icode, in_ifun, in_valA, in_valB, in_valC);
        m_valid = 1'b1;
        m_stat  = in_stat;
        m_icode = in_icode;
        m_cnd   = (in_icode == 4'h2 || in_icode == 4'h7) ? c : 1'b0;
        m_valE  = ex[63:0];
        m_valA  = in_valA;
        m_dstE  = (in_icode == 4'h2 && !c) ? 4'hF : in_dstE;
        m_dstM  = in_dstM;
        if (in_icode == 4'h6 && in_stat == 3'd1 && !cc_inhibit)
          m_cc = {ex[63:0] == 64'd0, ex[63], ex[64]};
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, !flush && (!m_valid || out_ready)});
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      check("cc", {61'd0, cc}, {61'd0, m_cc});
      if (m_valid) begin
        check("e_stat",  {61'd0, e_stat},  {61'd0, m_stat});
        check("e_icode", {60'd0, e_icode}, {60'd0, m_icode});
        check("e_cnd",   {63'd0, e_cnd},   {63'd0, m_cnd});
        check("e_valE",  e_valE, m_valE);
        check("e_valA",  e_valA, m_valA);
        check("e_dstE",  {60'd0, e_dstE},  {60'd0, m_dstE});
        check("e_dstM",  {60'd0, e_dstM},  {60'd0, m_dstM});
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] f,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                            input logic [3:0] de, input logic [3:0] dm);
    in_valid = 1'b1;
    in_stat = st; in_icode = ic; in_ifun = f;
    in_valA = a; in_valB = b; in_valC = c;
    in_dstE = de; in_dstM = dm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    rst_n = 1'b0;
    in_valid = 0; in_stat = 3'd1; in_icode = 0; in_ifun = 0;
    in_valA = 0; in_valB = 0; in_valC = 0; in_dstE = 4'hF; in_dstM = 4'hF;
    flush = 0; cc_inhibit = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst cc", {61'd0, cc}, 64'h4);
    check("rst e_dstE", {60'd0, e_dstE}, 64'hF);
    check("rst e_dstM", {60'd0, e_dstM}, 64'hF);
    check("rst e_icode", {60'd0, e_icode}, 64'd0);
    check("rst e_valE", e_valE, 64'd0);
    step();

    // subq 3-5
    set_bundle(3'd1, 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h3, 4'hF);
    #1;
    check("subq alu_sel", {62'd0, alu_sel}, 64'd3);
    check("subq alu_p", alu_p, 64'd3);
    check("subq alu_q", alu_q, 64'd5);
    step(); idle();
    check("subq e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("subq cc", {61'd0, cc}, 64'h2);

    // addq overflow, then cmovle not taken
    set_bundle(3'd1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h4, 4'hF);
    step();
    check("addq ovf e_valE", e_valE, 64'h8000_0000_0000_0000);
    check("addq ovf cc", {61'd0, cc}, 64'h3);
    set_bundle(3'd1, 4'h2, 4'h1, 64'h55, 64'd0, 64'd0, 4'h6, 4'hF);
    step(); idle();
    check("cmovle e_cnd", {63'd0, e_cnd}, 64'd0);
    check("cmovle e_dstE", {60'd0, e_dstE}, 64'hF);

    // pushq
    set_bundle(3'd1, 4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF);
    #1;
    check("pushq alu_sel", {62'd0, alu_sel}, 64'd2);
    step(); idle();
    check("pushq e_valE", e_valE, 64'hF8);
    check("pushq cc", {61'd0, cc}, 64'h3);

    // Stall: addq 20+10 then 3 cycles of backpressure with xorq waiting
    set_bundle(3'd1, 4'h6, 4'h0, 64'd10, 64'd20, 64'd0, 4'h5, 4'hF);
    step();
    out_ready = 1'b0;
    set_bundle(3'd1, 4'h6, 4'h3, 64'hFF, 64'h0F, 64'd0, 4'h7, 4'hF);
    held = e_valE;
    check("stall load e_valE", held, 64'd30);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall in_ready", {63'd0, in_ready}, 64'd0);
      step();
      check("stall e_valE", e_valE, 64'd30);
      check("stall e_dstE", {60'd0, e_dstE}, 64'h5);
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", {63'd0, in_ready}, 64'd1);
    step(); idle();
    check("release e_valE", e_valE, 64'hF0);
    check("release out_valid", {63'd0, out_valid}, 64'd1);

    // flush with an addq presented
    set_bundle(3'd1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
    flush = 1'b1;
    #1;
    check("flush in_ready", {63'd0, in_ready}, 64'd0);
    step(); idle(); flush = 1'b0;
    check("flush out_valid", {63'd0, out_valid}, 64'd0);
    check("flush cc", {61'd0, cc}, 64'h0);
    check("flush e_icode", {60'd0, e_icode}, 64'h1);
    check("flush e_dstE", {60'd0, e_dstE}, 64'hF);

    // cc_inhibit: bundle passes, zero result does not set ZF
    set_bundle(3'd1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF);
    cc_inhibit = 1'b1;
    step(); idle(); cc_inhibit = 1'b0;
    check("inhibit out_valid", {63'd0, out_valid}, 64'd1);
    check("inhibit cc", {61'd0, cc}, 64'h0);

    // Non-AOK: propagates with its stat, no cc write
    set_bundle(3'd3, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF);
    step(); idle();
    check("adr e_stat", {61'd0, e_stat}, 64'd3);
    check("adr cc", {61'd0, cc}, 64'h0);

    // subq 7-7 sets ZF; je taken; cmovne not taken
    set_bundle(3'd1, 4'h6, 4'h1, 64'd7, 64'd7, 64'd0, 4'h1, 4'hF);
    step();
    check("zero cc", {61'd0, cc}, 64'h4);
    set_bundle(3'd1, 4'h7, 4'h3, 64'd0, 64'd0, 64'h400, 4'hF, 4'hF);
    step();
    check("je e_cnd", {63'd0, e_cnd}, 64'd1);
    set_bundle(3'd1, 4'h2, 4'h4, 64'h9, 64'd0, 64'd0, 4'h3, 4'hF);
    step(); idle();
    check("cmovne e_dstE", {60'd0, e_dstE}, 64'hF);

    // popq then mrmovq
    set_bundle(3'd1, 4'hB, 4'h0, 64'h200, 64'h200, 64'd0, 4'h4, 4'h8);
    step();
    check("popq e_valE", e_valE, 64'h208);
    set_bundle(3'd1, 4'h5, 4'h0, 64'd0, 64'h1000, 64'h10, 4'hF, 4'h9);
    step(); idle();
    check("mrmovq e_valE", e_valE, 64'h1010);

    // Reset mid-stall: subq 1-2 sets SF, then async reset between edges
    set_bundle(3'd1, 4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h1, 4'hF);
    step(); idle();
    out_ready = 1'b0;
    check("pre-reset cc", {61'd0, cc}, 64'h2);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", {63'd0, out_valid}, 64'd0);
    check("async rst cc", {61'd0, cc}, 64'h4);
    check("async rst e_dstE", {60'd0, e_dstE}, 64'hF);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post-reset out_valid", {63'd0, out_valid}, 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
